// File: rtl/scr1_axi_mem_slave.sv
// AXI4 slave bridging single-beat AXI reads and writes onto the SCR1 memif request interface.
// One transaction is in flight at a time; unsupported bursts and sizes get an SLVERR response.
module scr1_axi_mem_slave #(
    parameter int SCR1_AXI_IDWIDTH = 4,
    parameter int SCR1_ADDR_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SCR1_AXI_IDWIDTH-1:0] awid,
    input  logic [SCR1_ADDR_WIDTH-1:0]  awaddr,
    input  logic [7:0]                  awlen,
    input  logic [2:0]                  awsize,
    input  logic [1:0]                  awburst,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [31:0]                 wdata,
    input  logic [3:0]                  wstrb,
    input  logic                        wlast,
    input  logic                        wvalid,
    output logic                        wready,
    output logic [SCR1_AXI_IDWIDTH-1:0] bid,
    output logic [1:0]                  bresp,
    output logic                        bvalid,
    input  logic                        bready,
    input  logic [SCR1_AXI_IDWIDTH-1:0] arid,
    input  logic [SCR1_ADDR_WIDTH-1:0]  araddr,
    input  logic [7:0]                  arlen,
    input  logic [2:0]                  arsize,
    input  logic [1:0]                  arburst,
    input  logic                        arvalid,
    output logic                        arready,
    output logic [SCR1_AXI_IDWIDTH-1:0] rid,
    output logic [31:0]                 rdata,
    output logic [1:0]                  rresp,
    output logic                        rlast,
    output logic                        rvalid,
    input  logic                        rready,
    output logic                        mem_req,
    input  logic                        mem_req_ack,
    output logic                        mem_cmd,
    output logic [1:0]                  mem_width,
    output logic [SCR1_ADDR_WIDTH-1:0]  mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic [31:0]                 mem_rdata,
    input  logic [1:0]                  mem_resp
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_W_DATA, ST_W_MEM, ST_W_DRAIN, ST_B_RESP, ST_R_MEM, ST_R_ERR, ST_R_RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] MEM_NOTRDY  = 2'd0;
    localparam logic [1:0] MEM_RDY_OK  = 2'd1;

    function automatic logic [31:0] lane_down(input logic [31:0] d, input logic [1:0] off);
        return d >> {off, 3'b000};
    endfunction

    function automatic logic [31:0] lane_up(input logic [31:0] d, input logic [1:0] off);
        return d << {off, 3'b000};
    endfunction

    function automatic logic xfer_unsupported(input logic [7:0] len, input logic [2:0] size,
                                              input logic [1:0] burst);
        return (len != 8'd0) || (size > 3'd2) || (burst != 2'b01);
    endfunction

    state_e                      state_r;
    logic                        last_rd_r;
    logic [SCR1_AXI_IDWIDTH-1:0] id_r;
    logic [SCR1_ADDR_WIDTH-1:0]  addr_r;
    logic [7:0]                  len_r;
    logic [1:0]                  size_r;
    logic [7:0]                  beat_cnt_r;
    logic                        grant_aw_s;
    logic                        grant_ar_s;
    logic                        mem_done_s;
    logic                        unused_s;

    assign unused_s = ^wstrb;
    assign awready  = grant_aw_s;
    assign arready  = grant_ar_s;

    // Round-robin address-channel grant, only offered while idle and out of reset
    always_comb begin
        grant_aw_s = 1'b0;
        grant_ar_s = 1'b0;
        if ((state_r == ST_IDLE) && rst_n) begin
            if (awvalid && (!arvalid || last_rd_r)) begin
                grant_aw_s = 1'b1;
            end else begin
                grant_ar_s = arvalid;
            end
        end else begin
            grant_aw_s = 1'b0;
            grant_ar_s = 1'b0;
        end
    end

    // A response only counts once the request has been acked (or in the ack cycle itself)
    always_comb begin
        mem_done_s = 1'b0;
        if (mem_resp != MEM_NOTRDY) begin
            mem_done_s = mem_req ? mem_req_ack : 1'b1;
        end else begin
            mem_done_s = 1'b0;
        end
    end

    // Transaction FSM with all AXI and memif outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            last_rd_r  <= 1'b1;
            id_r       <= '0;
            addr_r     <= '0;
            len_r      <= 8'd0;
            size_r     <= 2'd0;
            beat_cnt_r <= 8'd0;
            wready     <= 1'b0;
            bid        <= '0;
            bresp      <= 2'b00;
            bvalid     <= 1'b0;
            rid        <= '0;
            rdata      <= 32'd0;
            rresp      <= 2'b00;
            rlast      <= 1'b0;
            rvalid     <= 1'b0;
            mem_req    <= 1'b0;
            mem_cmd    <= 1'b0;
            mem_width  <= 2'd0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_aw_s) begin
                        id_r      <= awid;
                        addr_r    <= awaddr;
                        len_r     <= awlen;
                        size_r    <= awsize[1:0];
                        last_rd_r <= 1'b0;
                        wready    <= 1'b1;
                        state_r   <= xfer_unsupported(awlen, awsize, awburst) ? ST_W_DRAIN : ST_W_DATA;
                    end else if (grant_ar_s) begin
                        id_r      <= arid;
                        addr_r    <= araddr;
                        len_r     <= arlen;
                        size_r    <= arsize[1:0];
                        last_rd_r <= 1'b1;
                        if (xfer_unsupported(arlen, arsize, arburst)) begin
                            rvalid     <= 1'b1;
                            rid        <= arid;
                            rdata      <= 32'd0;
                            rresp      <= RESP_SLVERR;
                            rlast      <= (arlen == 8'd0);
                            beat_cnt_r <= 8'd0;
                            state_r    <= ST_R_ERR;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_cmd   <= 1'b0;
                            mem_width <= arsize[1:0];
                            mem_addr  <= araddr;
                            state_r   <= ST_R_MEM;
                        end
                    end
                end
                ST_W_DATA: begin
                    if (wvalid) begin
                        wready    <= 1'b0;
                        mem_wdata <= lane_down(wdata, addr_r[1:0]);
                        mem_req   <= 1'b1;
                        mem_cmd   <= 1'b1;
                        mem_width <= size_r;
                        mem_addr  <= addr_r;
                        state_r   <= ST_W_MEM;
                    end
                end
                ST_W_DRAIN: begin
                    if (wvalid && wlast) begin
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        bid     <= id_r;
                        bresp   <= RESP_SLVERR;
                        state_r <= ST_B_RESP;
                    end
                end
                ST_W_MEM: begin
                    if (mem_req && mem_req_ack) begin
                        mem_req <= 1'b0;
                    end
                    if (mem_done_s) begin
                        bvalid  <= 1'b1;
                        bid     <= id_r;
                        bresp   <= (mem_resp == MEM_RDY_OK) ? RESP_OKAY : RESP_SLVERR;
                        state_r <= ST_B_RESP;
                    end
                end
                ST_B_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_R_MEM: begin
                    if (mem_req && mem_req_ack) begin
                        mem_req <= 1'b0;
                    end
                    if (mem_done_s) begin
                        rvalid  <= 1'b1;
                        rid     <= id_r;
                        rdata   <= lane_up(mem_rdata, addr_r[1:0]);
                        rresp   <= (mem_resp == MEM_RDY_OK) ? RESP_OKAY : RESP_SLVERR;
                        rlast   <= 1'b1;
                        state_r <= ST_R_RESP;
                    end
                end
                ST_R_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        rlast   <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_R_ERR: begin
                    if (rready) begin
                        if (beat_cnt_r == len_r) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + 8'd1;
                            rlast      <= ((beat_cnt_r + 8'd1) == len_r);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scr1_axi_mem_slave.sv
// Scoreboard bench for scr1_axi_mem_slave: AXI master tasks, memif responder model and
// response monitors that pop expectations queued when each transaction is issued.
module tb_scr1_axi_mem_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, mem_addr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp, mem_width, mem_resp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] wdata, rdata, mem_wdata, mem_rdata;
    logic [3:0]  wstrb;
    logic        mem_req, mem_req_ack, mem_cmd;

    always #5 clk = ~clk;

    scr1_axi_mem_slave #(.SCR1_AXI_IDWIDTH(4), .SCR1_ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .mem_req(mem_req), .mem_req_ack(mem_req_ack), .mem_cmd(mem_cmd), .mem_width(mem_width),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    int total = 0;
    int bad = 0;

    logic [79:0] exp_mem_q[$];
    logic [79:0] exp_b_q[$];
    logic [79:0] exp_r_q[$];
    byte         grant_q[$];

    int          ack_delay = 0;
    logic [1:0]  resp_code = 2'd1;
    logic [31:0] rd_data_v = 32'd0;
    int          req_cycles = 0;
    int          req_cnt = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // memif target: acks after ack_delay cycles of mem_req, checking the request fields
    always @(posedge clk) begin
        #1;
        if (rst_n && mem_req) begin
            req_cycles++;
            if (req_cnt >= ack_delay) begin
                mem_req_ack = 1'b1;
                mem_resp    = resp_code;
                mem_rdata   = rd_data_v;
                req_cnt     = 0;
                if (exp_mem_q.size() == 0) chk("mem_unexpected", 80'(mem_addr), 80'hFFFF);
                else chk("memif", 80'({mem_cmd, mem_width, mem_addr, (mem_cmd ? mem_wdata : 32'h0)}),
                         exp_mem_q.pop_front());
            end else begin
                mem_req_ack = 1'b0;
                mem_resp    = 2'd0;
                req_cnt++;
            end
        end else begin
            mem_req_ack = 1'b0;
            mem_resp    = 2'd0;
            req_cnt     = 0;
        end
    end

    // Response and grant monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (bvalid && bready) begin
                if (exp_b_q.size() == 0) chk("b_unexpected", 80'({bid, bresp}), 80'hFFFF);
                else chk("bresp", 80'({bid, bresp}), exp_b_q.pop_front());
            end
            if (rvalid && rready) begin
                if (exp_r_q.size() == 0) chk("r_unexpected", 80'({rid, rdata, rresp, rlast}), 80'hFFFF);
                else chk("rbeat", 80'({rid, rdata, rresp, rlast}), exp_r_q.pop_front());
            end
            if (awvalid && awready) grant_q.push_back("W");
            if (arvalid && arready) grant_q.push_back("R");
        end
    end

    task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [2:0] sz,
                           input logic [7:0] len, input logic [1:0] bu);
        int t;
        @(posedge clk); #1;
        awvalid = 1'b1; awid = id; awaddr = a; awsize = sz; awlen = len; awburst = bu;
        t = 0;
        do begin @(negedge clk); t++; end while (!awready && t < 200);
        chk("aw_handshake", 80'(awready), 80'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic last);
        int t;
        @(posedge clk); #1;
        wvalid = 1'b1; wdata = d; wlast = last; wstrb = 4'hF;
        t = 0;
        do begin @(negedge clk); t++; end while (!wready && t < 200);
        chk("w_handshake", 80'(wready), 80'd1);
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [2:0] sz,
                           input logic [7:0] len, input logic [1:0] bu);
        int t;
        @(posedge clk); #1;
        arvalid = 1'b1; arid = id; araddr = a; arsize = sz; arlen = len; arburst = bu;
        t = 0;
        do begin @(negedge clk); t++; end while (!arready && t < 200);
        chk("ar_handshake", 80'(arready), 80'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("resp_pending", 80'(exp_b_q.size() + exp_r_q.size()), 80'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] d, input logic [31:0] exp_mwdata, input logic [1:0] exp_resp);
        exp_mem_q.push_back(80'({1'b1, sz[1:0], a, exp_mwdata}));
        exp_b_q.push_back(80'({id, exp_resp}));
        fork
            aw_send(id, a, sz, 8'd0, 2'b01);
            w_send(d, 1'b1);
        join
        wait_done();
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] mdata, input logic [31:0] exp_rdata);
        rd_data_v = mdata;
        exp_mem_q.push_back(80'({1'b0, sz[1:0], a, 32'h0}));
        exp_r_q.push_back(80'({id, exp_rdata, 2'b00, 1'b1}));
        ar_send(id, a, sz, 8'd0, 2'b01);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] grants;
        int t;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        awid = 4'd0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0;
        arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0;
        wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0;
        mem_req_ack = 1'b0; mem_resp = 2'd0; mem_rdata = 32'd0;

        #22;
        chk("reset_outputs", 80'(|{awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp,
                                   rlast, rvalid, mem_req, mem_cmd, mem_width, mem_addr, mem_wdata}), 80'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_valids", 80'({bvalid, rvalid, mem_req, wready}), 80'd0);

        // word write then read back
        do_write(4'd1, 32'h100, 3'd2, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
        do_read(4'd2, 32'h100, 3'd2, 32'hDEADBEEF, 32'hDEADBEEF);

        // byte lane alignment
        do_write(4'd3, 32'h103, 3'd0, 32'hAB000000, 32'h000000AB, 2'b00);
        do_read(4'd4, 32'h102, 3'd1, 32'h00001234, 32'h12340000);

        // memif stall then error
        ack_delay = 5; resp_code = 2'd2; req_cycles = 0;
        do_write(4'd5, 32'h200, 3'd2, 32'h11223344, 32'h11223344, 2'b10);
        chk("stall_req_cycles", 80'(req_cycles), 80'd6);
        ack_delay = 0; resp_code = 2'd1;

        // unsupported bursts and sizes never reach memif
        req_cycles = 0;
        for (int i = 0; i < 4; i++) exp_r_q.push_back(80'({4'd3, 32'h0, 2'b10, (i == 3)}));
        ar_send(4'd3, 32'h300, 3'd2, 8'd3, 2'b01);
        wait_done();
        exp_r_q.push_back(80'({4'd6, 32'h0, 2'b10, 1'b1}));
        ar_send(4'd6, 32'h304, 3'd3, 8'd0, 2'b01);
        wait_done();
        exp_b_q.push_back(80'({4'd4, 2'b10}));
        fork
            aw_send(4'd4, 32'h310, 3'd2, 8'd1, 2'b01);
            begin w_send(32'h1, 1'b0); w_send(32'h2, 1'b1); end
        join
        wait_done();
        exp_b_q.push_back(80'({4'd7, 2'b10}));
        fork
            aw_send(4'd7, 32'h314, 3'd2, 8'd0, 2'b00);
            w_send(32'h3, 1'b1);
        join
        wait_done();
        chk("err_no_mem_req", 80'(req_cycles), 80'd0);

        // read backpressure: payload stable while rready is low
        rready = 1'b0; rd_data_v = 32'hCAFEF00D;
        exp_mem_q.push_back(80'({1'b0, 2'd2, 32'h320, 32'h0}));
        exp_r_q.push_back(80'({4'd9, 32'hCAFEF00D, 2'b00, 1'b1}));
        fork
            ar_send(4'd9, 32'h320, 3'd2, 8'd0, 2'b01);
            begin
                t = 0;
                do begin @(negedge clk); t++; end while (!rvalid && t < 100);
                for (int i = 0; i < 3; i++) begin
                    chk("stall_rvalid", 80'(rvalid), 80'd1);
                    chk("stall_rdata", 80'(rdata), 80'hCAFEF00D);
                    @(negedge clk);
                end
                rready = 1'b1;
            end
        join
        wait_done();

        // simultaneous AW/AR: last grant was a read, so W, then R, then W
        grant_q.delete();
        rd_data_v = 32'h0B0B0B0B;
        exp_mem_q.push_back(80'({1'b1, 2'd2, 32'h400, 32'hA1A1A1A1}));
        exp_mem_q.push_back(80'({1'b0, 2'd2, 32'h404, 32'h0}));
        exp_mem_q.push_back(80'({1'b1, 2'd2, 32'h408, 32'hC3C3C3C3}));
        exp_b_q.push_back(80'({4'd6, 2'b00}));
        exp_b_q.push_back(80'({4'd8, 2'b00}));
        exp_r_q.push_back(80'({4'd7, 32'h0B0B0B0B, 2'b00, 1'b1}));
        fork
            begin aw_send(4'd6, 32'h400, 3'd2, 8'd0, 2'b01); aw_send(4'd8, 32'h408, 3'd2, 8'd0, 2'b01); end
            begin w_send(32'hA1A1A1A1, 1'b1); w_send(32'hC3C3C3C3, 1'b1); end
            ar_send(4'd7, 32'h404, 3'd2, 8'd0, 2'b01);
        join
        wait_done();
        grants = 24'd0;
        if (grant_q.size() == 3) grants = {grant_q[0], grant_q[1], grant_q[2]};
        chk("grant_order", 80'(grants), 80'("WRW"));

        // reset while a write request is pending on memif
        ack_delay = 1000;
        fork
            aw_send(4'd11, 32'h500, 3'd2, 8'd0, 2'b01);
            w_send(32'h77777777, 1'b1);
        join
        t = 0;
        while (!mem_req && t < 50) begin @(negedge clk); t++; end
        chk("pre_reset_mem_req", 80'(mem_req), 80'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_outputs", 80'(|{awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp,
                                      rlast, rvalid, mem_req, mem_cmd, mem_width, mem_addr, mem_wdata}), 80'd0);
        ack_delay = 0;
        @(negedge clk); rst_n = 1'b1;
        do_read(4'd10, 32'h504, 3'd2, 32'h55AA55AA, 32'h55AA55AA);

        chk("memif_pending", 80'(exp_mem_q.size()), 80'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scr1_axi_mem_slave.md
Name: scr1_axi_mem_slave

Overview:
AXI4 slave (responder) that converts incoming AXI read/write transactions into SCR1 core memory-interface requests. It lets an external AXI master (debug DMA, testbench master, SoC interconnect) reach memif-side targets such as TCM or the memory router. It handles one transaction at a time, single-beat data path, and reports an error for unsupported bursts and sizes.

Parameters:
SCR1_AXI_IDWIDTH, 4, width of AXI ID fields
SCR1_ADDR_WIDTH, 32, width of AXI and memif addresses

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
awid/awaddr/awlen/awsize/awburst  in  IDW/AW/8/3/2  write address channel
awvalid in 1; awready out 1  AW handshake
wdata/wstrb/wlast  in  32/4/1  write data channel
wvalid in 1; wready out 1  W handshake
bid/bresp  out  IDW/2  write response
bvalid out 1; bready in 1  B handshake
arid/araddr/arlen/arsize/arburst  in  IDW/AW/8/3/2  read address channel
arvalid in 1; arready out 1  AR handshake
rid/rdata/rresp/rlast  out  IDW/32/2/1  read data channel
rvalid out 1; rready in 1  R handshake
mem_req  out  1  memif request
mem_req_ack  in  1  memif request accepted
mem_cmd  out  1  SCR1_MEM_CMD_RD=0 / SCR1_MEM_CMD_WR=1
mem_width  out  2  type_scr1_mem_width_e (BYTE=0, HWORD=1, WORD=2)
mem_addr  out  AW  memif address
mem_wdata  out  32  memif write data, right-aligned
mem_rdata  in  32  memif read data, right-aligned
mem_resp  in  2  NOTRDY=0, RDY_OK=1, RDY_ER=2

Behaviour:
- Reset: all outputs are 0. State is IDLE. The round-robin pointer favours write.
- FSM states: IDLE, W_DATA, W_MEM, W_DRAIN, B_RESP, R_MEM, R_ERR, R_RESP.
- IDLE arbitration:
  - If only one of awvalid/arvalid is high, grant that channel.
  - If both are high, grant the channel not granted last (round-robin).
  - awready/arready are driven combinationally high in IDLE for the granted channel only.
- On the AW or AR handshake, latch id, addr, len, size into registers.
  - err is set when len!=0, size>2, or burst!=INCR.
- Write path:
  - AW accepted: go to W_DATA if err=0, else W_DRAIN.
  - W_DATA: wready=1. On W handshake, latch wdata>>(8*addr[1:0]) into mem_wdata and go to W_MEM. wstrb is ignored.
  - W_DRAIN: wready=1. Accept beats until wlast, then go to B_RESP with bresp=SLVERR (2'b10). No memif access.
  - W_MEM: mem_req=1, mem_cmd=WR, mem_width=size[1:0], mem_addr=latched addr. mem_req stays high until mem_req_ack, then drops the next cycle.
  - W_MEM completion: wait for mem_resp!=NOTRDY (may coincide with the ack cycle). RDY_OK gives bresp=OKAY; RDY_ER gives bresp=SLVERR. Then go to B_RESP.
  - B_RESP: bvalid=1, bid=latched id. Hold until bready, then go to IDLE.
- Read path:
  - AR accepted: go to R_MEM if err=0, else R_ERR.
  - R_MEM: same memif request rules with mem_cmd=RD. On the response, latch rdata=mem_rdata<<(8*addr[1:0]) and set rresp from mem_resp. Go to R_RESP.
  - R_RESP: rvalid=1, rlast=1, rid=latched id. Hold until rready, then go to IDLE.
  - R_ERR: emits exactly len+1 beats with rdata=0 and rresp=SLVERR, using an 8-bit beat counter. rlast is asserted on beat len. Each beat holds until rready. Go to IDLE after the last beat.
- All AXI output payloads stay stable while valid is high and ready is low.
- The response ready signals (bready, rready) low for many cycles causes a stall only; no state is lost.
- A memif response arriving with no request outstanding (state not W_MEM/R_MEM) is ignored.
- AXI is single-outstanding: at most one transaction in flight, and no new AW/AR is accepted outside IDLE.
- Reset mid-transaction: the FSM returns to IDLE immediately and all outputs go to 0. Any pending memif request is dropped.
- Throughput: minimum AW→B is 4 cycles (AW, W, memif with ack+resp in the same cycle, B). Minimum AR→R is 3 cycles.

Test Plan:
- Word write then read: AW addr=0x100 size=2, W data=0xDEADBEEF → mem_cmd=WR, mem_width=WORD, mem_wdata=0xDEADBEEF, bresp=0. A following AR to 0x100 with mem_rdata=0xDEADBEEF → rdata=0xDEADBEEF, rresp=0, rlast=1.
- Byte lane alignment: write size=0 addr=0x103 wdata=0xAB000000 → mem_wdata=0x000000AB. Read size=1 addr=0x102 with mem_rdata=0x1234 → rdata=0x12340000.
- Memif error and stall: mem_req_ack held low 5 cycles, then mem_resp=RDY_ER → mem_req stays high for exactly 6 cycles, bresp=2'b10, bid echoes awid=0x5.
- Unsupported burst: AR arlen=3 → 4 R beats with rresp=2'b10 and rlast only on the 4th, no mem_req. AW awlen=1 → two W beats accepted, bresp=2'b10.
- Arbitration and backpressure: awvalid and arvalid both high for back-to-back transactions → grants alternate W,R,W. rready low 3 cycles → rvalid and rdata held stable.
- Reset during W_MEM with mem_req=1: assert rst_n=0 → all outputs 0 asynchronously. After release, a new AR completes normally.
